// File: rtl/servant_uart_rx.sv
// 8N1 UART receiver for the servant SoC: 2-flop synchroniser, bit-timing FSM and a
// small circular FIFO polled over a single-register-pair Wishbone slave.
module servant_uart_rx #(
  parameter int CLKS_PER_BIT = 139,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        i_rx,
  input  logic        i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [15:0]      HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0]      FULL_M1 = 16'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  // Synchroniser, FSM and FIFO state.
  logic             rx_meta_q, rxs_q;
  state_e           state_q, state_d;
  logic [15:0]      baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovr_q, ovr_d, ferr_q, ferr_d;
  logic             ack_q, ack_d;
  logic [31:0]      rdt_q, rdt_d;

  logic push, push_ok, pop, ferr_set, ovr_set;
  logic empty, full, wb_txn, rd, wr;
  logic unused_dat;

  assign unused_dat = ^{i_wb_dat[31:4], i_wb_dat[1:0]};

  // Both synchroniser flops reset high so a reset never looks like a start bit.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          baud_d  = HALF_M1;
        end
      end
      S_START: begin
        if (baud_q != 16'd0) begin
          baud_d = baud_q - 16'd1;
        end else if (!rxs_q) begin
          state_d = S_DATA;
          baud_d  = FULL_M1;
          bit_d   = 3'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (baud_q != 16'd0) begin
          baud_d = baud_q - 16'd1;
        end else begin
          shreg_d = {rxs_q, shreg_q[7:1]};
          baud_d  = FULL_M1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_q != 16'd0) begin
          baud_d = baud_q - 16'd1;
        end else if (rxs_q) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end else begin
          ferr_set = 1'b1;
          state_d  = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A bus transaction is taken on the edge that raises ack.
  assign wb_txn = i_wb_cyc & ~ack_q;
  assign rd     = wb_txn & ~i_wb_we;
  assign wr     = wb_txn & i_wb_we;
  assign empty  = (count_q == '0);
  assign full   = (count_q == DEPTH_C);
  assign pop    = rd & ~i_wb_adr & ~empty;
  assign push_ok = push & (~full | pop);
  assign ovr_set = push & full & ~pop;

  always_comb begin
    ack_d    = i_wb_cyc & ~ack_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push_ok) count_d = count_q - CNT_W'(1);

    // Clear first so a simultaneous set event wins.
    ovr_d  = ovr_q;
    ferr_d = ferr_q;
    if (wr && i_wb_adr && i_wb_dat[2]) ovr_d  = 1'b0;
    if (wr && i_wb_adr && i_wb_dat[3]) ferr_d = 1'b0;
    if (ovr_set)  ovr_d  = 1'b1;
    if (ferr_set) ferr_d = 1'b1;

    rdt_d = rdt_q;
    if (rd) begin
      if (i_wb_adr)    rdt_d = {28'd0, ferr_q, ovr_q, full, ~empty};
      else if (!empty) rdt_d = {23'd0, 1'b1, mem_q[rd_ptr_q]};
      else             rdt_d = 32'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q  <= S_IDLE;
      baud_q   <= 16'd0;
      bit_q    <= 3'd0;
      shreg_q  <= 8'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
      ack_q    <= 1'b0;
      rdt_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
      ack_q    <= ack_d;
      rdt_q    <= rdt_d;
    end
  end

  // NOTE: FIFO storage has no reset; occupancy and pointers alone define which entries are valid.
  always_ff @(posedge wb_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shreg_q;
  end

  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;
  assign o_irq    = (count_q != '0);

endmodule

// File: tb/tb_servant_uart_rx.sv
// Scoreboard bench for servant_uart_rx: directed serial frames and Wishbone accesses,
// expected read data queued at issue time and compared by an ack-driven monitor.
module tb_servant_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic        i_rx = 1'b1;
  logic        i_wb_adr = 1'b0;
  logic [31:0] i_wb_dat = 32'd0;
  logic        i_wb_we = 1'b0;
  logic        i_wb_cyc = 1'b0;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;
  logic        o_irq;

  servant_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .i_rx     (i_rx),
    .i_wb_adr (i_wb_adr),
    .i_wb_dat (i_wb_dat),
    .i_wb_we  (i_wb_we),
    .i_wb_cyc (i_wb_cyc),
    .o_wb_rdt (o_wb_rdt),
    .o_wb_ack (o_wb_ack),
    .o_irq    (o_irq)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct {
    logic        chk;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every ack consumes one queued expectation.
  always @(negedge wb_clk) begin
    if (!wb_rst && o_wb_ack) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_ack: got ack with rdt 0x%08h expected no ack", o_wb_rdt);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.chk) check(e.name, o_wb_rdt, e.val);
      end
    end
  end

  task automatic wb_read(input logic adr, input logic [31:0] exp, input string name);
    @(negedge wb_clk);
    exp_q.push_back('{1'b1, exp, name});
    i_wb_cyc = 1'b1;
    i_wb_adr = adr;
    i_wb_we  = 1'b0;
    @(negedge wb_clk);
    i_wb_cyc = 1'b0;
    @(negedge wb_clk);
  endtask

  task automatic wb_write(input logic adr, input logic [31:0] dat);
    @(negedge wb_clk);
    exp_q.push_back('{1'b0, 32'd0, "write"});
    i_wb_cyc = 1'b1;
    i_wb_adr = adr;
    i_wb_we  = 1'b1;
    i_wb_dat = dat;
    @(negedge wb_clk);
    i_wb_cyc = 1'b0;
    i_wb_we  = 1'b0;
    i_wb_dat = 32'd0;
    @(negedge wb_clk);
  endtask

  // Start bit, 8 data bits LSB-first, stop bit; the line is left at the stop level.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge wb_clk);
      i_rx = frame[i];
      repeat (CPB - 1) @(negedge wb_clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("reset_ack", {31'd0, o_wb_ack}, 32'd0);
    check("reset_rdt", o_wb_rdt, 32'd0);
    check("reset_irq", {31'd0, o_irq}, 32'd0);
    repeat (3) @(negedge wb_clk);
    wb_rst = 1'b0;
    repeat (3) @(negedge wb_clk);
    wb_read(1'b1, 32'h0, "status_after_reset");

    // Two bytes at exact baud, then an empty read.
    send_byte(8'h55, 1'b1);
    send_byte(8'hA3, 1'b1);
    check("irq_two_bytes", {31'd0, o_irq}, 32'd1);
    wb_read(1'b0, 32'h155, "data_55");
    check("irq_one_left", {31'd0, o_irq}, 32'd1);
    wb_read(1'b0, 32'h1A3, "data_A3");
    check("irq_after_drain", {31'd0, o_irq}, 32'd0);
    wb_read(1'b0, 32'h000, "data_empty");

    // Overrun: five bytes into a four-entry FIFO.
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    wb_read(1'b1, 32'h7, "status_overrun");
    for (int i = 1; i <= 4; i++) wb_read(1'b0, 32'h100 + 32'(i), "data_fill");
    wb_write(1'b1, 32'h4);
    wb_read(1'b1, 32'h0, "status_ovr_cleared");

    // Framing error followed by a held break.
    send_byte(8'h7E, 1'b0);
    repeat (3 * 10 * CPB) @(negedge wb_clk);
    i_rx = 1'b1;
    repeat (20) @(negedge wb_clk);
    wb_read(1'b1, 32'h8, "status_ferr");
    send_byte(8'h42, 1'b1);
    wb_read(1'b0, 32'h142, "data_after_break");
    wb_write(1'b1, 32'h8);
    wb_read(1'b1, 32'h0, "status_ferr_cleared");

    // Short glitch on the idle line must be rejected.
    @(negedge wb_clk);
    i_rx = 1'b0;
    repeat (6) @(negedge wb_clk);
    i_rx = 1'b1;
    repeat (40) @(negedge wb_clk);
    check("irq_after_glitch", {31'd0, o_irq}, 32'd0);
    wb_read(1'b1, 32'h0, "status_after_glitch");
    send_byte(8'h5A, 1'b1);
    wb_read(1'b0, 32'h15A, "data_after_glitch");

    // Full FIFO, DATA read lands on the push edge of 0x99 (push at 155 cycles after fall).
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    wb_read(1'b1, 32'h3, "status_full");
    fork
      send_byte(8'h99, 1'b1);
      begin
        repeat (3 + CPB / 2 + 9 * CPB - 1) @(negedge wb_clk);
        wb_read(1'b0, 32'h111, "data_on_push");
      end
    join
    repeat (5) @(negedge wb_clk);
    wb_read(1'b1, 32'h3, "status_full_no_ovr");
    wb_read(1'b0, 32'h122, "data_22");
    wb_read(1'b0, 32'h133, "data_33");
    wb_read(1'b0, 32'h144, "data_44");
    wb_read(1'b0, 32'h199, "data_99_last");
    wb_read(1'b1, 32'h0, "status_drained");

    // Asynchronous reset during data bit 4 with a byte pending and nonzero rdt.
    send_byte(8'h77, 1'b1);
    wb_read(1'b1, 32'h1, "status_pending");
    fork
      send_byte(8'h3C, 1'b1);
      begin
        repeat (3 + CPB / 2 + CPB + 4 * CPB + 4) @(negedge wb_clk);
        #3 wb_rst = 1'b1;
        #1;
        check("midframe_rst_ack", {31'd0, o_wb_ack}, 32'd0);
        check("midframe_rst_rdt", o_wb_rdt, 32'd0);
        check("midframe_rst_irq", {31'd0, o_irq}, 32'd0);
      end
    join
    repeat (2) @(negedge wb_clk);
    wb_rst = 1'b0;
    repeat (20) @(negedge wb_clk);
    wb_read(1'b1, 32'h0, "status_after_rst");
    send_byte(8'h3C, 1'b1);
    wb_read(1'b0, 32'h13C, "data_3C");
    check("irq_end", {31'd0, o_irq}, 32'd0);

    repeat (5) @(negedge wb_clk);
    check("pending_acks", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/servant_uart_rx.md
# servant_uart_rx

Wishbone-attached UART receiver for the servant SoC on the Tang Nano 9K: deserialises 8N1 frames arriving on a board pin into a small FIFO that SERV polls over the Wishbone bus. It is the receive counterpart to the GPIO-driven serial output `q` and sits on the `wb_clk`/`wb_rst` domain produced by the Gowin rPLL clock generator.

## Interface
- `CLKS_PER_BIT`, default 139: `wb_clk` cycles per bit (16 MHz / 115200); legal range 8..65535.
- `FIFO_DEPTH`, default 4: receive FIFO entries; power of two, 2..16.
- `wb_clk`  in  1  system clock; the only clock.
- `wb_rst`  in  1  reset; asynchronous, active-high.
- `i_rx`  in  1  serial input, idle high, asynchronous to `wb_clk`.
- `i_wb_adr`  in  1  register select: 0 = DATA, 1 = STATUS.
- `i_wb_dat`  in  32  write data.
- `i_wb_we`  in  1  write enable.
- `i_wb_cyc`  in  1  cycle valid.
- `o_wb_rdt`  out  32  read data, registered.
- `o_wb_ack`  out  1  single-cycle acknowledge.
- `o_irq`  out  1  high while FIFO non-empty.

## Operation
- `i_rx` passes through a 2-flop synchroniser (both flops reset to 1); the FSM uses only the synchronised value `rxs`.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. Bit counter 3 bits, baud counter 16 bits.
  - IDLE: `rxs`=0 -> START, baud counter loaded with `CLKS_PER_BIT/2 - 1`.
  - START: on counter 0, `rxs`=0 -> DATA (counter `CLKS_PER_BIT-1`, bit index 0); `rxs`=1 -> IDLE (glitch rejected, nothing recorded).
  - DATA: on counter 0, shift `rxs` in LSB-first, reload counter; after bit 7 -> STOP.
  - STOP: on counter 0, `rxs`=1 -> push byte, IDLE; `rxs`=0 -> set FERR, discard byte, WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs`=1, then IDLE (a break never produces repeated frames).
- FIFO: circular, pointers wrap modulo `FIFO_DEPTH`, occupancy counter 0..`FIFO_DEPTH`.
  - Push while full with no pop in the same cycle: byte dropped, OVR set, contents untouched.
  - Push and pop in the same cycle: both performed, including when full; occupancy unchanged.
- Register map:
  - DATA read: `[7:0]` head byte, `[8]` valid (FIFO was non-empty), `[31:9]` 0; pops if non-empty. Read when empty returns 0, no pop.
  - STATUS read: `[0]` non-empty, `[1]` full, `[2]` OVR, `[3]` FERR, `[31:4]` 0; no side effects.
  - STATUS write: 1 in bit 2 clears OVR, 1 in bit 3 clears FERR; other bits ignored. A set event and a clear in the same cycle leaves the flag set.
  - DATA write: acked, no effect.
- `o_irq` = occupancy != 0 (combinational from registered occupancy).

## Timing
- Reset values: `o_wb_ack`=0, `o_wb_rdt`=0, `o_irq`=0, FIFO empty, OVR=FERR=0, FSM IDLE, synchroniser=1. Reset asserted mid-frame aborts the frame; nothing is pushed.
- Wishbone: `o_wb_ack` <= `i_wb_cyc` & !`o_wb_ack`; ack exactly one cycle after `i_wb_cyc` rises, never two consecutive cycles. `o_wb_rdt` and the pop/clear side effect occur on the same edge that raises ack; `o_wb_rdt` holds until the next ack.
- Back-to-back cycles (cyc held high) ack every second cycle; each ack is one transaction.
- Start detect latency: 2 cycles (synchroniser) + 1 (IDLE sample).
- Push occurs mid stop bit: 2 + 1 + `CLKS_PER_BIT/2` + 9×`CLKS_PER_BIT` cycles (±1) after the falling edge on `i_rx`; `o_irq` rises the following cycle.
- Tolerates ±3 % baud mismatch at `CLKS_PER_BIT` >= 16.

## Test plan
- `CLKS_PER_BIT`=16: send 0x55 then 0xA3 at exact baud -> DATA reads return 0x155, 0x1A3, then 0x000; `o_irq` falls after the second pop.
- Send 5 bytes (0x01..0x05) with `FIFO_DEPTH`=4 and no reads -> STATUS=0x7 (non-empty, full, OVR); DATA reads return 0x101..0x104; STATUS write 0x4 -> STATUS=0x0.
- Frame 0x7E with stop bit low, then line held low 3 frame times -> FERR set, FIFO empty, no further pushes; release line, send 0x42 -> DATA read 0x142.
- Low pulse of 6 cycles on idle `i_rx` -> no push, FERR=0, FSM back in IDLE.
- FIFO full, DATA read issued on the exact cycle a new byte 0x99 pushes -> OVR stays 0, occupancy stays 4, 0x99 read last.
- Assert `wb_rst` asynchronously during DATA bit 4 of a frame -> all outputs reset immediately; after release, a clean 0x3C frame is read as 0x13C.
